// File: rtl/oam_dma_pkg.sv
// Shared CPU bus definitions for the sprite DMA engine.
// DMA register/destination addresses and the DMA state encoding.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [15:0] DEST_ADDR    = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE,
        RESTORE
    } dma_state_t;

    function automatic logic is_dma_trigger(
        input logic [15:0] addr,
        input logic        rw
    );
        return !rw && (addr == DMA_REG_ADDR);
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: stalls the core and copies page {page,00..ff} to the OAM port.
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN slot after HALT.
module oam_dma
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_o,
    input  logic        cpu_rw,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_o,
    output logic        bus_rw,
    output logic        cpu_ready,
    output logic        dma_active
);

    dma_state_t  state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        trig;
    logic        halt_align;

    assign trig = is_dma_trigger(cpu_addr, cpu_rw);

`ifdef OAM_DMA_ALIGN_EN
    logic cyc_odd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_odd <= 1'b0;
        end else begin
            cyc_odd <= ~cyc_odd;
        end
    end

    assign halt_align = cyc_odd;
`else
    assign halt_align = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            page       <= 8'h00;
            idx        <= 8'h00;
            cpu_ready  <= 1'b1;
            dma_active <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        page      <= cpu_data_o;
                        idx       <= 8'h00;
                        state     <= HALT;
                        cpu_ready <= 1'b0;
                    end
                end
                HALT: begin
                    // The core ignores ready on writes, so let them drain first.
                    if (!cpu_rw) begin
                        if (trig) begin
                            page <= cpu_data_o;
                        end
                    end else begin
                        state      <= halt_align ? ALIGN : READ;
                        dma_active <= 1'b1;
                    end
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hff) ? RESTORE : READ;
                end
                RESTORE: begin
                    state      <= IDLE;
                    cpu_ready  <= 1'b1;
                    dma_active <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RESTORE re-presents the core address so its read data lands as ready rises.
    always_comb begin
        bus_addr   = cpu_addr;
        bus_data_o = cpu_data_o;
        bus_rw     = cpu_rw;
        unique case (state)
            ALIGN, RESTORE: begin
                bus_rw = 1'b1;
            end
            READ: begin
                bus_addr = {page, idx};
                bus_rw   = 1'b1;
            end
            WRITE: begin
                bus_addr   = DEST_ADDR;
                bus_rw     = 1'b0;
                bus_data_o = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a synchronous memory model.
// Honours OAM_DMA_ALIGN_EN when computing expected stall lengths.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_o;
    logic        cpu_rw;
    logic [7:0]  mem_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_o;
    logic        bus_rw;
    logic        cpu_ready;
    logic        dma_active;

    oam_dma dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_data_o (cpu_data_o),
        .cpu_rw     (cpu_rw),
        .mem_rdata  (mem_rdata),
        .bus_addr   (bus_addr),
        .bus_data_o (bus_data_o),
        .bus_rw     (bus_rw),
        .cpu_ready  (cpu_ready),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mem [0:65535];
    bit         mem_loaded = 1'b0;
    logic [7:0] wq[$];
    int         bad0 = 0;
    logic       par = 1'b0;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h59;
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < 65536; a++) begin
                mem[a] <= pat(16'(a));
            end
            mem[16'hc123] <= 8'hea;
            mem_loaded    <= 1'b1;
        end else begin
            if (!bus_rw) mem[bus_addr] <= bus_data_o;
            mem_rdata <= mem[bus_addr];
        end
    end

    always @(posedge clk) par <= rst_n ? ~par : 1'b0;

    always @(negedge clk) begin
        if (rst_n && !bus_rw && bus_addr == 16'h2004) wq.push_back(bus_data_o);
        if (rst_n && dma_active && bus_addr == 16'h0000) bad0++;
    end

    task automatic chk(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_addr   = a;
        cpu_data_o = d;
        cpu_rw     = rw;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rw;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_rw;
    } pt_vec_t;

    typedef struct {
        logic [7:0] page;
        logic       trig_par;
        int         nwr;
        int         exp_base;
    } xfer_t;

    pt_vec_t pv[6];
    xfer_t   xv[4];

    task automatic run_xfer(input xfer_t x, input int id);
        int stall;
        int act_cnt;
        int c;
        int exp_stall;
        int data_bad;
        logic halt_par;
        logic [15:0] prev;
        logic align;
        prev = 16'h0;
        if (par != x.trig_par) begin
            drive(16'h8000, 8'h00, 1'b1);
            next_cycle();
        end
        wq.delete();
        bad0 = 0;
        drive(16'h4014, x.page, 1'b0);
        next_cycle();
        stall   = 0;
        act_cnt = 0;
        for (int k = 0; k < x.nwr; k++) begin
            drive(16'h01fd - 16'(k), 8'h10 + 8'(k), 1'b0);
            @(negedge clk);
            chk($sformatf("halt_wr_addr[%0d.%0d]", id, k),
                bus_addr == 16'h01fd - 16'(k), bus_addr, 16'h01fd - 16'(k));
            chk($sformatf("halt_wr_data[%0d.%0d]", id, k),
                bus_data_o == 8'h10 + 8'(k) && !bus_rw && !cpu_ready,
                {bus_rw, cpu_ready, bus_data_o}, 8'h10 + 8'(k));
            stall++;
            next_cycle();
        end
        drive(16'hc123, 8'h00, 1'b1);
        halt_par = par;
        c = 0;
        @(negedge clk);
        while (!cpu_ready && c < 1000) begin
            stall++;
            if (dma_active) act_cnt++;
            prev = bus_addr;
            @(negedge clk);
            c++;
        end
`ifdef OAM_DMA_ALIGN_EN
        align = halt_par;
`else
        align = 1'b0;
`endif
        exp_stall = x.exp_base + x.nwr + (align ? 1 : 0);
        chk($sformatf("stall_len[%0d]", id), stall == exp_stall, stall, exp_stall);
        chk($sformatf("active_len[%0d]", id), act_cnt == exp_stall - x.nwr - 1,
            act_cnt, exp_stall - x.nwr - 1);
        chk($sformatf("restore_addr[%0d]", id), prev == 16'hc123, prev, 16'hc123);
        chk($sformatf("restore_data[%0d]", id), mem_rdata == 8'hea, mem_rdata, 8'hea);
        next_cycle();
        chk($sformatf("write_count[%0d]", id), wq.size() == 256, wq.size(), 256);
        data_bad = 0;
        for (int i = 0; i < wq.size() && i < 256; i++) begin
            if (wq[i] != (8'(i) ^ x.page ^ 8'h59)) data_bad++;
        end
        chk($sformatf("write_data[%0d]", id), data_bad == 0, data_bad, 0);
        chk($sformatf("no_addr0[%0d]", id), bad0 == 0, bad0, 0);
    endtask

    initial begin
        int c;
        pv[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1};
        pv[1] = '{16'h0200, 8'h3c, 1'b0, 16'h0200, 8'h3c, 1'b0};
        pv[2] = '{16'h4015, 8'h03, 1'b0, 16'h4015, 8'h03, 1'b0};
        pv[3] = '{16'h4014, 8'h07, 1'b1, 16'h4014, 8'h07, 1'b1};
        pv[4] = '{16'h4013, 8'h99, 1'b0, 16'h4013, 8'h99, 1'b0};
        pv[5] = '{16'hfffc, 8'h00, 1'b1, 16'hfffc, 8'h00, 1'b1};

        xv[0] = '{8'h03, 1'b0, 0, 514};
        xv[1] = '{8'h03, 1'b1, 0, 514};
        xv[2] = '{8'h03, 1'b0, 2, 514};
        xv[3] = '{8'hff, 1'b1, 0, 514};

        rst_n = 1'b0;
        drive(16'h8000, 8'h00, 1'b1);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_ready", cpu_ready == 1'b1, cpu_ready, 1);
        chk("reset_active", dma_active == 1'b0, dma_active, 0);
        chk("reset_passthru", bus_addr == 16'h8000 && bus_rw, bus_addr, 16'h8000);
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(pv[i].addr, pv[i].wdata, pv[i].rw);
            @(negedge clk);
            chk($sformatf("pt_bus[%0d]", i),
                bus_addr == pv[i].exp_addr && bus_data_o == pv[i].exp_data &&
                bus_rw == pv[i].exp_rw,
                {bus_rw, bus_data_o, bus_addr},
                {pv[i].exp_rw, pv[i].exp_data, pv[i].exp_addr});
            chk($sformatf("pt_ctl[%0d]", i), cpu_ready && !dma_active,
                {cpu_ready, dma_active}, 2'b10);
            next_cycle();
        end

        for (int i = 0; i < 4; i++) run_xfer(xv[i], i);

        // Reset in the middle of a transfer.
        wq.delete();
        drive(16'h4014, 8'h03, 1'b0);
        next_cycle();
        drive(16'hc123, 8'h00, 1'b1);
        c = 0;
        while (wq.size() < 100 && c < 2000) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("midop_reach100", wq.size() == 100, wq.size(), 100);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        drive(16'h0200, 8'h77, 1'b0);
        @(negedge clk);
        chk("midop_ready", cpu_ready && !dma_active, {cpu_ready, dma_active}, 2'b10);
        chk("midop_passthru",
            bus_addr == 16'h0200 && bus_data_o == 8'h77 && !bus_rw,
            {bus_rw, bus_data_o, bus_addr}, {1'b0, 8'h77, 16'h0200});
        next_cycle();
        rst_n = 1'b1;
        drive(16'hc123, 8'h00, 1'b1);
        repeat (40) next_cycle();
        @(negedge clk);
        chk("midop_no_more_wr", wq.size() == 100, wq.size(), 100);
        chk("midop_idle", cpu_ready && !dma_active, {cpu_ready, dma_active}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
